// File: rtl/wb_reg_bank_if_if.sv
// rtl/wb_reg_bank_if_if.sv - Wishbone classic bus bundle for the register-bank front-end
interface wb_reg_bank_if_if #(
  parameter int DATA_W = 32,
  parameter int EN_W   = (DATA_W - 1) / 8 + 1,
  parameter int ADDR_W = 8
);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [EN_W-1:0]   wb_sel_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_reg_bank_if.sv
// rtl/wb_reg_bank_if.sv - Wishbone slave decoding to per-register write strobes and registered reads
module wb_reg_bank_if #(
  parameter int DATA_W = 32,
  parameter int EN_W   = (DATA_W - 1) / 8 + 1,
  parameter int ADDR_W = 8,
  parameter int NREG   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_reg_bank_if_if.slave        wb,
  output logic [NREG-1:0]        reg_we,
  output logic [EN_W-1:0]        reg_en,
  output logic [DATA_W-1:0]      reg_d,
  input  logic [NREG*DATA_W-1:0] rd_bus,
  output logic [NREG-1:0]        wr_pulse
);
  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic {IDLE, ACK} state_t;

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic [NREG-1:0]   we_q, we_d;
  logic [NREG-1:0]   pulse_q;
  logic [EN_W-1:0]   en_q, en_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  logic [IDX_W-1:0]  idx;
  logic              mapped;
  logic [NREG-1:0]   idx_onehot;
  logic [DATA_W-1:0] rd_word;
  logic              unused_adr_bits;

  assign idx             = wb.wb_adr_i[ADDR_W-1:2];
  assign mapped          = (32'(idx) < NREG);
  assign unused_adr_bits = ^wb.wb_adr_i[1:0];

  always_comb begin
    idx_onehot = '0;
    rd_word    = '0;
    for (int i = 0; i < NREG; i++) begin
      if (mapped && (32'(idx) == i)) begin
        idx_onehot[i] = 1'b1;
        rd_word       = rd_bus[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next values of every output are computed here so all outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    we_d    = '0;
    en_d    = '0;
    d_d     = '0;
    dat_d   = '0;
    case (state_q)
      IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (wb.wb_we_i) begin
            if (mapped) begin
              we_d = idx_onehot;
              en_d = wb.wb_sel_i;
              d_d  = wb.wb_dat_i;
            end
          end else begin
            dat_d = rd_word;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      we_q    <= '0;
      pulse_q <= '0;
      en_q    <= '0;
      d_q     <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      pulse_q <= we_d;
      en_q    <= en_d;
      d_q     <= d_d;
      dat_q   <= dat_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign reg_we      = we_q;
  assign wr_pulse    = pulse_q;
  assign reg_en      = en_q;
  assign reg_d       = d_q;
endmodule

// File: tb/tb_wb_reg_bank_if.sv
// tb/tb_wb_reg_bank_if.sv - scoreboard bench for wb_reg_bank_if with four byte-enable registers
module tb_wb_reg_bank_if;
  localparam int DATA_W = 32;
  localparam int EN_W   = 4;
  localparam int ADDR_W = 8;
  localparam int NREG   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reg_rst = 1'b1;
  logic [NREG-1:0]        reg_we;
  logic [EN_W-1:0]        reg_en;
  logic [DATA_W-1:0]      reg_d;
  logic [NREG*DATA_W-1:0] rd_bus;
  logic [NREG-1:0]        wr_pulse;

  wb_reg_bank_if_if #(.DATA_W(DATA_W), .EN_W(EN_W), .ADDR_W(ADDR_W)) wb ();

  wb_reg_bank_if #(.DATA_W(DATA_W), .EN_W(EN_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb.slave),
    .reg_we   (reg_we),
    .reg_en   (reg_en),
    .reg_d    (reg_d),
    .rd_bus   (rd_bus),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  // Byte-enable register file standing in for the downstream register instances.
  logic [DATA_W-1:0] regs [NREG];
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      for (int b = 0; b < EN_W; b++) begin
        if (reg_rst) regs[i][b*8 +: 8] <= 8'h00;
        else if (reg_we[i] && reg_en[b]) regs[i][b*8 +: 8] <= reg_d[b*8 +: 8];
      end
    end
  end
  always_comb begin
    for (int i = 0; i < NREG; i++) rd_bus[i*DATA_W +: DATA_W] = regs[i];
  end

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    logic [3:0]  we;
    logic [3:0]  en;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   cycle   = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  logic started = 1'b0;
  logic prev_ack = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cycle);
    end
  endtask

  // Monitor: pops one expectation per acknowledge and checks quiet outputs otherwise.
  always @(negedge clk) begin
    if (started) begin
      if (wb.wb_ack_o === 1'b1) begin
        check("ack_not_consecutive", {31'd0, prev_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_latency", cycle, e.cyc);
          check("dat_o", wb.wb_dat_o, e.dat);
          check("reg_we", {28'd0, reg_we}, {28'd0, e.we});
          check("wr_pulse", {28'd0, wr_pulse}, {28'd0, e.we});
          check("reg_en", {28'd0, reg_en}, {28'd0, e.en});
          check("reg_d", reg_d, e.d);
        end
      end else begin
        check("idle_strobes", {20'd0, reg_we, wr_pulse, reg_en}, 32'd0);
        check("idle_data", reg_d | wb.wb_dat_o, 32'd0);
      end
      prev_ack = wb.wb_ack_o;
    end
  end

  task automatic push_exp(input int c, input logic [31:0] dat, input logic [3:0] we,
                          input logic [3:0] en, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.dat = dat; e.we = we; e.en = en; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_sel_i = sel;  wb.wb_dat_i = dat;
  endtask

  task automatic release_bus();
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = 8'h00; wb.wb_sel_i = 4'h0; wb.wb_dat_i = 32'h0;
  endtask

  // Single transfer; cyc/stb drop during the ack cycle.
  task automatic xfer(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic [31:0] exp_dat,
                      input logic [3:0] exp_we, input logic [3:0] exp_en, input logic [31:0] exp_d);
    @(negedge clk);
    drive(we, adr, sel, dat);
    push_exp(cycle + 1, exp_dat, exp_we, exp_en, exp_d);
    @(posedge clk);
    @(negedge clk);
    release_bus();
    @(posedge clk);
  endtask

  task automatic wr(input logic [7:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                    input logic [3:0] exp_we, input logic [3:0] exp_en, input logic [31:0] exp_d);
    xfer(1'b1, adr, sel, dat, 32'h0, exp_we, exp_en, exp_d);
  endtask

  task automatic rd(input logic [7:0] adr, input logic [31:0] exp_dat);
    xfer(1'b0, adr, 4'hf, 32'h0, exp_dat, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    release_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; reg_rst = 1'b0; started = 1'b1;
    check("reset_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("reset_reg_we", {28'd0, reg_we}, 32'd0);

    rd(8'h00, 32'h0); rd(8'h04, 32'h0); rd(8'h08, 32'h0); rd(8'h0c, 32'h0);

    wr(8'h04, 4'hf, 32'h12345678, 4'b0010, 4'hf, 32'h12345678);
    rd(8'h04, 32'h12345678);
    wr(8'h04, 4'h2, 32'heeeeeeee, 4'b0010, 4'h2, 32'heeeeeeee);
    rd(8'h04, 32'h1234ee78);
    wr(8'h07, 4'h8, 32'hcc000000, 4'b0010, 4'h8, 32'hcc000000);
    rd(8'h04, 32'hcc34ee78);

    wr(8'h10, 4'hf, 32'hdeadbeef, 4'b0000, 4'h0, 32'h0);
    rd(8'h10, 32'h0);
    rd(8'hfc, 32'h0);
    rd(8'h00, 32'h0); rd(8'h04, 32'hcc34ee78); rd(8'h08, 32'h0); rd(8'h0c, 32'h0);

    // Three writes with cyc/stb held high throughout.
    @(negedge clk);
    drive(1'b1, 8'h00, 4'hf, 32'h11111111);
    push_exp(cycle + 1, 32'h0, 4'b0001, 4'hf, 32'h11111111);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 8'h08, 4'hf, 32'h22222222);
    push_exp(cycle + 2, 32'h0, 4'b0100, 4'hf, 32'h22222222);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b1, 8'h0c, 4'hf, 32'h33333333);
    push_exp(cycle + 2, 32'h0, 4'b1000, 4'hf, 32'h33333333);
    repeat (2) @(posedge clk);
    @(negedge clk);
    release_bus();
    @(posedge clk);
    rd(8'h00, 32'h11111111); rd(8'h08, 32'h22222222); rd(8'h0c, 32'h33333333);

    wr(8'h00, 4'h0, 32'h55555555, 4'b0001, 4'h0, 32'h55555555);
    rd(8'h00, 32'h11111111);

    // Reset coinciding with a write request: no ack, no strobe, register untouched.
    @(negedge clk);
    drive(1'b1, 8'h08, 4'hf, 32'h99999999);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    release_bus();
    check("rst_abort_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("rst_abort_we", {28'd0, reg_we}, 32'd0);
    @(posedge clk);
    rd(8'h08, 32'h22222222);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    check("missing_acks", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_reg_bank_if.md
Name: wb_reg_bank_if

Overview:
- Wishbone classic slave front-end for the SD controller register bank.
- Sits directly upstream of the byte_en_reg instances.
- Decodes each Wishbone transaction into a one-hot per-register write strobe, plus a byte-enable vector and write data shared by all registers.
- Returns registered read data and a single-cycle acknowledge.

Parameters:
- DATA_W, 32, register/bus data width in bits.
- EN_W, (DATA_W-1)/8+1, number of byte enables.
- ADDR_W, 8, Wishbone byte-address width.
- NREG, 8, number of mapped 32-bit registers at word offsets 0..NREG-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  ADDR_W  byte address; bits [1:0] ignored.
- wb_sel_i  in  EN_W  byte selects.
- wb_dat_i  in  DATA_W  write data.
- wb_dat_o  out  DATA_W  read data, valid while wb_ack_o=1.
- wb_ack_o  out  1  transfer acknowledge.
- reg_we  out  NREG  one-hot write strobe per register; drives the byte_en_reg "we" inputs.
- reg_en  out  EN_W  byte enables, common to all registers.
- reg_d  out  DATA_W  write data, common to all registers.
- rd_bus  in  NREG*DATA_W  flattened register contents; register i occupies [i*DATA_W +: DATA_W].
- wr_pulse  out  NREG  one-cycle "register i was written" pulse for side effects such as command start.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE. wb_ack_o, reg_we, reg_en, reg_d, wb_dat_o and wr_pulse are all 0. Reset mid-transaction aborts it: no ack, and no write if the strobe has not yet been issued.
- Index: idx = wb_adr_i[ADDR_W-1:2]. mapped = (idx < NREG).
- FSM, two states:
  - IDLE: if wb_cyc_i & wb_stb_i at edge N, go to ACK and latch we, idx, mapped, sel and dat.
  - ACK: unconditionally return to IDLE at the next edge.
- Cycle N+1 (state ACK):
  - wb_ack_o=1 for exactly this one cycle.
  - Write & mapped: reg_we[idx]=1, reg_en=latched sel, reg_d=latched dat. The target register updates at edge N+2.
  - wr_pulse[idx]=1 under the same condition, registered together with reg_we.
  - Read & mapped: wb_dat_o = rd_bus slice idx as sampled at edge N.
  - Read & unmapped: wb_dat_o = 0.
  - Write & unmapped: ack is still given, but reg_we and wr_pulse stay 0 (silent discard, no bus error).
- Outside the ACK cycle, reg_we=0, reg_en=0, reg_d=0, wr_pulse=0 and wb_dat_o=0.
- Back-to-back requests: stb held high after an ack is treated as a new request at the edge that leaves ACK. Maximum throughput is one transfer per 2 cycles. wb_ack_o is never high in two consecutive cycles.
- wb_sel_i=0 on a write: ack is given and reg_we pulses with reg_en=0, so the register is unchanged; wr_pulse still fires.
- wb_cyc_i dropping while in ACK: the latched write still completes (it is committed at edge N).
- Read-after-write: a read issued in the cycle immediately after a write ack returns the new value. rd_bus updates at N+2; the read is sampled at the next IDLE edge, at or after N+2.
- Inputs other than cyc/stb are ignored in IDLE when no request is present.
- EN_W partial byte: the upper byte enable covers the remaining DATA_W-8*(EN_W-1) bits.

Test Plan (DATA_W=32, NREG=4, rd_bus driven by 4 byte_en_reg instances fed from reg_we/reg_en/reg_d):
- Reset held 3 cycles, then released → wb_ack_o=0, reg_we=0, all registers 0.
- Write adr=0x04, sel=4'hf, dat=0x12345678 → ack exactly one cycle after stb; reg_we=4'b0010 and wr_pulse=4'b0010 for one cycle. Then read adr=0x04 → wb_dat_o=0x12345678 in the ack cycle.
- Write adr=0x04, sel=4'h2, dat=0xeeeeeeee → read back 0x1234ee78. Write adr=0x07 (low bits set), sel=4'h8, dat=0xcc000000 → read back 0xcc34ee78.
- Write adr=0x10 (idx 4, unmapped), dat=0xdeadbeef → ack is given, reg_we=0, wr_pulse=0, registers 0–3 unchanged. Read adr=0x10 → wb_dat_o=0.
- stb/cyc held high for 3 writes to adr 0x00, 0x08 and 0x0c → acks in alternate cycles only (never consecutive); each reg_we is one-hot and correct; values read back correctly.
- rst asserted in the cycle after a write request edge → no ack and no reg_we at the following edge; the register is unchanged; the state is IDLE after reset.
